// File: rtl/float_div16_if.sv
// Start/done handshake bundle for the half-precision divider.
interface float_div16_if;
    logic        start;
    logic [15:0] float_a;
    logic [15:0] float_b;
    logic        ready;
    logic        done;
    logic [15:0] quotient;

    modport master (output start, float_a, float_b, input ready, done, quotient);
    modport slave  (input start, float_a, float_b, output ready, done, quotient);
endinterface

// File: rtl/float_div16.sv
// Sequential half-precision divider: restoring mantissa division, one quotient
// bit per cycle, fixed 14-cycle latency from accepted start to done.
module float_div16 (
    input  logic        clk,
    input  logic        rst_n,
    float_div16_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

    typedef struct packed {
        logic              sign;
        logic              zero_a;
        logic              zero_b;
        logic signed [6:0] exp;
        logic [10:0]       fb;
    } op_t;

    localparam logic [14:0] MAX_MAG = 15'h7BFF;

    state_t      state, state_nxt;
    op_t         op, op_cap;
    logic [12:0] rem, rem_sub, rem_nxt;
    logic [11:0] q;
    logic [3:0]  cnt;
    logic [15:0] quot_r, res;
    logic        ready, done, accept, qbit;
    logic signed [6:0] e_norm;
    logic [9:0]  m_norm;

    assign accept       = ready & bus.start;
    assign bus.ready    = ready;
    assign bus.done     = done;
    assign bus.quotient = quot_r;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.start) state_nxt = DIV;
            end
            DIV:  if (cnt == 4'd11) state_nxt = NORM;
            NORM: state_nxt = DONE;
            DONE: begin
                ready     = 1'b1;
                done      = 1'b1;
                state_nxt = bus.start ? DIV : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand decode at acceptance; exponent kept signed so under/overflow are visible.
    always_comb begin
        op_cap.sign   = bus.float_a[15] ^ bus.float_b[15];
        op_cap.zero_a = (bus.float_a[14:10] == 5'd0);
        op_cap.zero_b = (bus.float_b[14:10] == 5'd0);
        op_cap.exp    = $signed({2'b00, bus.float_a[14:10]} - {2'b00, bus.float_b[14:10]} + 7'd15);
        op_cap.fb     = {1'b1, bus.float_b[9:0]};
    end

    // One restoring step: subtract if it fits, then shift for the next bit.
    always_comb begin
        qbit    = (rem >= {2'b00, op.fb});
        rem_sub = qbit ? (rem - {2'b00, op.fb}) : rem;
        rem_nxt = rem_sub << 1;
    end

    // Fraction ratio lies in (0.5, 2), so at most one position of normalisation.
    always_comb begin
        if (q[11]) begin
            m_norm = q[10:1];
            e_norm = op.exp;
        end else begin
            m_norm = q[9:0];
            e_norm = op.exp - 7'sd1;
        end
        if (op.zero_a)               res = 16'h0000;
        else if (op.zero_b)          res = {op.sign, MAX_MAG};
        else if (e_norm <= 7'sd0)    res = 16'h0000;
        else if (e_norm >= 7'sd31)   res = {op.sign, MAX_MAG};
        else                         res = {op.sign, e_norm[4:0], m_norm};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op     <= '0;
            rem    <= '0;
            q      <= '0;
            cnt    <= '0;
            quot_r <= '0;
        end else begin
            if (accept) begin
                op  <= op_cap;
                rem <= {2'b01, bus.float_a[9:0]};
                q   <= '0;
                cnt <= '0;
            end else if (state == DIV) begin
                rem <= rem_nxt;
                q   <= {q[10:0], qbit};
                cnt <= cnt + 4'd1;
            end
            if (state == NORM) quot_r <= res;
        end
    end
endmodule

// File: tb/tb_float_div16.sv
// Scoreboard bench for float_div16: expectations queued at issue, checked at done.
module tb_float_div16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    logic [15:0] exp_q[$];

    float_div16_if bus();

    float_div16 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
        int fa, fb, qq, e, m;
        logic s;
        s = a[15] ^ b[15];
        if (a[14:10] == 5'd0) return 16'h0000;
        if (b[14:10] == 5'd0) return {s, 15'h7BFF};
        fa = 1024 + int'(a[9:0]);
        fb = 1024 + int'(b[9:0]);
        qq = (fa * 2048) / fb;
        e  = int'(a[14:10]) - int'(b[14:10]) + 15;
        if (qq >= 2048) m = (qq >> 1) & 1023;
        else begin
            m = qq & 1023;
            e = e - 1;
        end
        if (e <= 0)  return 16'h0000;
        if (e >= 31) return {s, 15'h7BFF};
        return {s, e[4:0], m[9:0]};
    endfunction

    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        bus.float_a = a;
        bus.float_b = b;
        bus.start   = 1'b1;
        exp_q.push_back(model(a, b));
    endtask

    // Returns cycles from issue to done, or -1 if the bound expires.
    task automatic wait_done(input bit drop_start, output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (drop_start && c == 1) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    function automatic logic [15:0] pop_exp();
        if (exp_q.size() == 0) return 16'hxxxx;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset();
        int lat;
        logic [15:0] ev;
        bus.start = 1'b0; bus.float_a = '0; bus.float_b = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.quotient !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_state ready=%b done=%b q=%h required 1/0/0000", bus.ready, bus.done, bus.quotient);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(16'h3C00, 16'h3C00);
        wait_done(1'b1, lat);
        ev = pop_exp();
        n_vec++;
        if (lat !== 14) begin n_err++; $display("FAIL reset_first_latency got %0d required 14", lat); end
        n_vec++;
        if (bus.quotient !== ev) begin n_err++; $display("FAIL reset_first_quot got %h required %h", bus.quotient, ev); end
        @(posedge clk); #1;
        n_vec++;
        if (bus.done !== 1'b0 || bus.ready !== 1'b1) begin
            n_err++;
            $display("FAIL done_single_cycle done=%b ready=%b required 0/1", bus.done, bus.ready);
        end
    endtask

    task automatic test_vectors(input string name, input logic [15:0] va[], input logic [15:0] vb[]);
        int lat;
        logic [15:0] ev;
        foreach (va[i]) begin
            issue(va[i], vb[i]);
            @(posedge clk); #1;
            bus.start = 1'b0;
            n_vec++;
            if (bus.ready !== 1'b0) begin n_err++; $display("FAIL %s_busy %h/%h ready=%b required 0", name, va[i], vb[i], bus.ready); end
            bus.float_a = 16'h1234; bus.float_b = 16'hFFFF;
            wait_done(1'b0, lat);
            if (lat > 0) lat = lat + 1;
            ev = pop_exp();
            n_vec++;
            if (lat !== 14) begin n_err++; $display("FAIL %s_latency %h/%h got %0d required 14", name, va[i], vb[i], lat); end
            n_vec++;
            if (bus.quotient !== ev) begin n_err++; $display("FAIL %s_quot %h/%h got %h required %h", name, va[i], vb[i], bus.quotient, ev); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_basic();
        logic [15:0] va[] = '{16'h4600, 16'h3C00, 16'hC000};
        logic [15:0] vb[] = '{16'h4000, 16'h4200, 16'h4000};
        test_vectors("basic", va, vb);
    endtask

    task automatic test_special();
        logic [15:0] va[] = '{16'h3C00, 16'h0000, 16'h0000, 16'h0400, 16'h7800, 16'hBC00, 16'h03FF};
        logic [15:0] vb[] = '{16'h0000, 16'h4200, 16'h0000, 16'h7800, 16'h0400, 16'h0155, 16'hC200};
        test_vectors("special", va, vb);
    endtask

    task automatic test_hold_start();
        int lat;
        logic [15:0] ev;
        issue(16'h4600, 16'h4000);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c == 5) begin bus.float_a = 16'h3C00; bus.float_b = 16'h4200; end
            if (bus.done === 1'b1) begin lat = c; break; end
        end
        ev = pop_exp();
        n_vec++;
        if (lat !== 14) begin n_err++; $display("FAIL hold_latency1 got %0d required 14", lat); end
        n_vec++;
        if (bus.quotient !== ev) begin n_err++; $display("FAIL hold_quot1 got %h required %h", bus.quotient, ev); end
        exp_q.push_back(model(16'h3C00, 16'h4200));
        wait_done(1'b1, lat);
        ev = pop_exp();
        n_vec++;
        if (lat !== 14) begin n_err++; $display("FAIL hold_latency2 got %0d required 14", lat); end
        n_vec++;
        if (bus.quotient !== ev) begin n_err++; $display("FAIL hold_quot2 got %h required %h", bus.quotient, ev); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [15:0] ev;
        issue(16'h4600, 16'h4000);
        wait_done(1'b1, lat);
        ev = pop_exp();
        n_vec++;
        if (bus.quotient !== ev || lat !== 14) begin
            n_err++; $display("FAIL b2b_first got %h lat %0d required %h lat 14", bus.quotient, lat, ev);
        end
        issue(16'h3C00, 16'h4200);
        wait_done(1'b1, lat);
        ev = pop_exp();
        n_vec++;
        if (bus.quotient !== ev || lat !== 14) begin
            n_err++; $display("FAIL b2b_second got %h lat %0d required %h lat 14", bus.quotient, lat, ev);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat, pulses;
        logic [15:0] ev;
        bus.float_a = 16'h4600; bus.float_b = 16'h4000; bus.start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (c == 1) bus.start = 1'b0;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_vec++;
        if (bus.done !== 1'b0 || bus.quotient !== 16'h0000 || bus.ready !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_state done=%b q=%h ready=%b required 0/0000/1", bus.done, bus.quotient, bus.ready);
        end
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) pulses++;
        end
        n_vec++;
        if (pulses !== 0) begin n_err++; $display("FAIL midreset_no_done got %0d pulses required 0", pulses); end
        issue(16'h3C00, 16'h4200);
        wait_done(1'b1, lat);
        ev = pop_exp();
        n_vec++;
        if (bus.quotient !== ev || lat !== 14) begin
            n_err++; $display("FAIL midreset_recover got %h lat %0d required %h lat 14", bus.quotient, lat, ev);
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [15:0] rand_op();
        logic [4:0] e;
        logic [15:0] r;
        r = 16'($urandom);
        e = ($urandom_range(0, 15) == 0) ? 5'd0 : 5'($urandom_range(1, 30));
        return {r[15], e, r[9:0]};
    endfunction

    task automatic test_random();
        int lat;
        logic [15:0] ev, a, b;
        a = rand_op(); b = rand_op();
        issue(a, b);
        for (int i = 0; i < 2000; i++) begin
            wait_done(1'b1, lat);
            ev = pop_exp();
            n_vec++;
            if (bus.quotient !== ev || lat !== 14) begin
                n_err++;
                $display("FAIL random_%0d %h/%h got %h lat %0d required %h lat 14", i, a, b, bus.quotient, lat, ev);
            end
            if (lat < 0) break;
            if (i < 1999) begin
                a = rand_op(); b = rand_op();
                issue(a, b);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_special();
        test_hold_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
